sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
// - Shares the single SDRAM controller request port between three masters: video DMA (port 0),
//   TG68 CPU (port 1) and aux/DMA (port 2).
// - Fixed priority: 0 > 1 > 2. One transaction is in flight at a time.
// - Registers the grant and returns read data and ack to the winning master.
// - Sits between the TG68Test bus masters and the SDRAM controller, in the clk domain.
// PARAMETERS
// - ADDR_W        24  word address width (all ports)
// - DATA_W        16  data width (all ports)
// - STARVE_LIMIT  32  cycles a lower-priority request may wait before promotion (ARB_STARVE_GUARD_EN only)
// PORTS
// - clk            in   1       system clock
// - reset          in   1       synchronous, active-high reset
// - reqN           in   1       N=0..2; request, held high until ackN
// - addrN          in   ADDR_W  N=0..2; address, stable while reqN high
// - wrN            in   1       N=0..2; 1 = write, 0 = read
// - wdataN         in   DATA_W  N=0..2; write data
// - bselN          in   2       N=0..2; byte enables, active-high, [1] = upper byte
// - ackN           out  1       N=0..2; one-cycle completion pulse
// - rdata          out  DATA_W  read data shared by all ports; valid on the cycle ackN is high
// - sdr_req        out  1       request to controller, held until sdr_ack
// - sdr_addr       out  ADDR_W  registered address of granted port
// - sdr_wr         out  1       registered write flag
// - sdr_wdata      out  DATA_W  registered write data
// - sdr_bsel       out  2       registered byte enables
// - sdr_ack        in   1       controller completion pulse; sdr_rdata is valid with it
// - sdr_rdata      in   DATA_W  controller read data
// - grant          out  2       granted port index; 3 = none (debug/LED)
// BEHAVIOUR
// - Reset:
//   - state IDLE; all ack*, sdr_req, sdr_wr = 0.
//   - sdr_addr, sdr_wdata, rdata = 0; sdr_bsel = 2'b00; grant = 3; starve counters = 0.
// - FSM states:
//   - IDLE: choose the highest-priority active req; latch its addr/wr/wdata/bsel into the sdr_* regs;
//     set grant; go to ISSUE. If no req is active, stay in IDLE.
//   - ISSUE: sdr_req = 1; go to WAIT.
//   - WAIT: hold sdr_req = 1 and all sdr_* regs. On sdr_ack: sdr_req <= 0, rdata <= sdr_rdata,
//     ack[grant] <= 1, go to DONE.
//   - DONE: ack pulse is visible for this one cycle; grant <= 3; go to IDLE.
// - Latency:
//   - req sampled at edge E gives sdr_req high after E+1.
//   - sdr_ack at edge A gives ackN high after A+1.
//   - Minimum request-to-ack is 3 cycles plus controller latency.
// - Handshake:
//   - A master must drop reqN on the cycle after ackN.
//   - Because DONE skips arbitration, a master that drops req on that cycle is never re-granted for the
//     same access.
//   - A req that goes low before ack is a protocol violation; the access still completes and ack still pulses.
// - sdr_ack is ignored in IDLE, ISSUE and DONE (no spurious ackN).
// - Simultaneous requests: the lowest index wins. The losers keep req high and are evaluated again at
//   the next IDLE.
// - Back-to-back: with req0 continuously re-asserted, port 0 is served every 4+L cycles and ports 1/2
//   starve (without the macro).
// - Reset mid-transaction:
//   - Returns to IDLE in the next cycle with outputs at reset values.
//   - The controller is reset by the same signal.
//   - No ackN is issued for the aborted access.
// - Only the granted ackN is ever high; at most one ack bit is high per cycle.
// CONFIGURATION
// - ARB_STARVE_GUARD_EN defined:
//   - Ports 1 and 2 each have a 6-bit wait counter, saturating at STARVE_LIMIT.
//   - A counter increments each cycle its req is high and the port is not granted; it clears when the
//     port is granted.
//   - In IDLE, a port whose counter reached STARVE_LIMIT beats port 0. If ports 1 and 2 are both
//     promoted, port 1 wins.
// - ARB_STARVE_GUARD_EN undefined: no counters; strict fixed priority as above.
// TESTING
// 1. Reset: assert reset 2 cycles -> grant=3, sdr_req=0, ack=000, rdata=0.
// 2. Single read: req1 with addr1=24'h000100, controller sdr_ack 5 cycles after sdr_req with
//    rdata 16'hBEEF -> sdr_addr=24'h000100, sdr_wr=0, ack1 one cycle later, rdata=16'hBEEF.
// 3. Contention: req0, req1 and req2 rise on the same cycle, all writes -> serviced in order 0,1,2.
//    Each sdr_wdata matches its port; exactly three ack pulses.
// 4. Spurious ack: pulse sdr_ack while in IDLE -> no ackN and no state change.
// 5. Reset mid-WAIT: assert reset while sdr_req=1 -> next cycle sdr_req=0 and grant=3;
//    a following sdr_ack produces no ackN.
// 6. Starvation (macro on, STARVE_LIMIT=8): req0 always asserted, req2 held -> port 2 is granted
//    after 8 waiting cycles. With the macro off, port 2 is never granted.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for sdram_port_arbiter: three master request ports plus the SDRAM controller port.
// The arbiter uses the slave modport; the masters/controller side uses the master modport.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              req0, req1, req2;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic              wr0, wr1, wr2;
    logic [DATA_W-1:0] wdata0, wdata1, wdata2;
    logic [1:0]        bsel0, bsel1, bsel2;
    logic              ack0, ack1, ack2;
    logic [DATA_W-1:0] rdata;
    logic              sdr_req;
    logic [ADDR_W-1:0] sdr_addr;
    logic              sdr_wr;
    logic [DATA_W-1:0] sdr_wdata;
    logic [1:0]        sdr_bsel;
    logic              sdr_ack;
    logic [DATA_W-1:0] sdr_rdata;
    logic [1:0]        grant;

    modport slave (
        input  req0, req1, req2, addr0, addr1, addr2, wr0, wr1, wr2,
        input  wdata0, wdata1, wdata2, bsel0, bsel1, bsel2,
        output ack0, ack1, ack2, rdata,
        output sdr_req, sdr_addr, sdr_wr, sdr_wdata, sdr_bsel, grant,
        input  sdr_ack, sdr_rdata
    );

    modport master (
        output req0, req1, req2, addr0, addr1, addr2, wr0, wr1, wr2,
        output wdata0, wdata1, wdata2, bsel0, bsel1, bsel2,
        input  ack0, ack1, ack2, rdata,
        input  sdr_req, sdr_addr, sdr_wr, sdr_wdata, sdr_bsel, grant,
        output sdr_ack, sdr_rdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Fixed-priority (0 > 1 > 2) arbiter sharing one SDRAM controller port between three masters.
// Optional ARB_STARVE_GUARD_EN promotes ports 1/2 after STARVE_LIMIT cycles of waiting.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 32
) (
    input  logic                clk,
    input  logic                reset,
    sdram_port_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [1:0] NONE  = 2'd3;

    // The wait counters are 6 bits wide, so the limit must fit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 63) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..63");
    end

    function automatic logic [2:0] port_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        grant_r;
    logic              sdr_req_r;
    logic [ADDR_W-1:0] sdr_addr_r;
    logic              sdr_wr_r;
    logic [DATA_W-1:0] sdr_wdata_r;
    logic [1:0]        sdr_bsel_r;
    logic [DATA_W-1:0] rdata_r;
    logic [2:0]        ack_r;

    logic [2:0]        req_s;
    logic [1:0]        pick_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_wr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [1:0]        sel_bsel_s;

    assign req_s = {bus.req2, bus.req1, bus.req0};

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [5:0] LIMIT = 6'(STARVE_LIMIT);
    logic [5:0] wait1_r;
    logic [5:0] wait2_r;
    logic       promo1_s;
    logic       promo2_s;

    assign promo1_s = (wait1_r >= LIMIT);
    assign promo2_s = (wait2_r >= LIMIT);

    // Winner selection: promoted ports 1/2 first, then strict fixed priority.
    always_comb begin
        pick_s = NONE;
        if (req_s[1] && promo1_s) begin
            pick_s = 2'd1;
        end else if (req_s[2] && promo2_s) begin
            pick_s = 2'd2;
        end else if (req_s[0]) begin
            pick_s = 2'd0;
        end else if (req_s[1]) begin
            pick_s = 2'd1;
        end else if (req_s[2]) begin
            pick_s = 2'd2;
        end else begin
            pick_s = NONE;
        end
    end

    // Saturating wait counters; cleared when the port wins arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait1_r <= 6'd0;
            wait2_r <= 6'd0;
        end else begin
            if (state_r == IDLE && pick_s == 2'd1) begin
                wait1_r <= 6'd0;
            end else if (bus.req1 && grant_r != 2'd1 && wait1_r < LIMIT) begin
                wait1_r <= wait1_r + 6'd1;
            end else begin
                wait1_r <= wait1_r;
            end
            if (state_r == IDLE && pick_s == 2'd2) begin
                wait2_r <= 6'd0;
            end else if (bus.req2 && grant_r != 2'd2 && wait2_r < LIMIT) begin
                wait2_r <= wait2_r + 6'd1;
            end else begin
                wait2_r <= wait2_r;
            end
        end
    end
`else
    // Winner selection: strict fixed priority, lowest index first.
    always_comb begin
        pick_s = NONE;
        if (req_s[0]) begin
            pick_s = 2'd0;
        end else if (req_s[1]) begin
            pick_s = 2'd1;
        end else if (req_s[2]) begin
            pick_s = 2'd2;
        end else begin
            pick_s = NONE;
        end
    end
`endif

    // Request-field mux for the chosen port.
    always_comb begin
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wr_s    = 1'b0;
        sel_wdata_s = {DATA_W{1'b0}};
        sel_bsel_s  = 2'b00;
        case (pick_s)
            2'd0: begin
                sel_addr_s  = bus.addr0;
                sel_wr_s    = bus.wr0;
                sel_wdata_s = bus.wdata0;
                sel_bsel_s  = bus.bsel0;
            end
            2'd1: begin
                sel_addr_s  = bus.addr1;
                sel_wr_s    = bus.wr1;
                sel_wdata_s = bus.wdata1;
                sel_bsel_s  = bus.bsel1;
            end
            2'd2: begin
                sel_addr_s  = bus.addr2;
                sel_wr_s    = bus.wr2;
                sel_wdata_s = bus.wdata2;
                sel_bsel_s  = bus.bsel2;
            end
            default: begin
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wr_s    = 1'b0;
                sel_wdata_s = {DATA_W{1'b0}};
                sel_bsel_s  = 2'b00;
            end
        endcase
    end

    // Transaction FSM; DONE deliberately skips arbitration so a finishing master can drop req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            grant_r     <= NONE;
            sdr_req_r   <= 1'b0;
            sdr_addr_r  <= {ADDR_W{1'b0}};
            sdr_wr_r    <= 1'b0;
            sdr_wdata_r <= {DATA_W{1'b0}};
            sdr_bsel_r  <= 2'b00;
            rdata_r     <= {DATA_W{1'b0}};
            ack_r       <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 3'b000;
                    if (pick_s != NONE) begin
                        grant_r     <= pick_s;
                        sdr_addr_r  <= sel_addr_s;
                        sdr_wr_r    <= sel_wr_s;
                        sdr_wdata_r <= sel_wdata_s;
                        sdr_bsel_r  <= sel_bsel_s;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    sdr_req_r <= 1'b1;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (bus.sdr_ack) begin
                        sdr_req_r <= 1'b0;
                        rdata_r   <= bus.sdr_rdata;
                        ack_r     <= port_onehot(grant_r);
                        state_r   <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    ack_r   <= 3'b000;
                    grant_r <= NONE;
                    state_r <= IDLE;
                end
                default: begin
                    ack_r     <= 3'b000;
                    grant_r   <= NONE;
                    sdr_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack_r[0];
    assign bus.ack1      = ack_r[1];
    assign bus.ack2      = ack_r[2];
    assign bus.rdata     = rdata_r;
    assign bus.sdr_req   = sdr_req_r;
    assign bus.sdr_addr  = sdr_addr_r;
    assign bus.sdr_wr    = sdr_wr_r;
    assign bus.sdr_wdata = sdr_wdata_r;
    assign bus.sdr_bsel  = sdr_bsel_r;
    assign bus.grant     = grant_r;
endmodule
